// File: rtl/branch_monitor.sv
// branch_monitor: commit-path branch statistics with a 2-bit bimodal predictor.
// Counts branches, taken branches and mispredictions (saturating), and
// exposes them through a one-cycle request/response read port. A clear
// sweep resets the counters and rewrites every predictor entry to weak
// not-taken.
// Optional feature: define BRMON_GSHARE_EN to XOR a global history
// register into the predictor index (gshare).
module branch_monitor #(
    parameter int CNT_W = 32,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic             seen,
    input  logic             taken,
    input  logic             int_taken,
    input  logic [31:0]      pc,
    input  logic             clr,
    output logic             busy,
    output logic             mispredict,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [31:0]      rd_data
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  ptr;
    logic [1:0]        tbl [ENTRIES];
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  mis_cnt;
    logic              accept;
    logic              start_clr;
    logic [IDX_W-1:0]  idx;
    logic              pred;
    logic [31:0]       rd_mux;
    logic              unused_pc;

    assign unused_pc = ^{pc[31:IDX_W+2], pc[1:0]};

`ifdef BRMON_GSHARE_EN
    logic [IDX_W-1:0]  ghr;

    assign idx = pc[IDX_W+1:2] ^ ghr;

    // Global history shifts in the outcome of every accepted branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (start_clr) begin
            ghr <= '0;
        end else if (accept) begin
            ghr <= {ghr[IDX_W-2:0], taken};
        end
    end
`else
    assign idx = pc[IDX_W+1:2];
`endif

    assign pred = tbl[idx][1];
    assign busy = (state == SWEEP);

    // State register for the clear sweep FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus accept/clear strobes; clr takes priority over a commit
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        start_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_next = SWEEP;
                    start_clr  = 1'b1;
                end else begin
                    accept = inst_valid & seen & ~int_taken;
                end
            end
            SWEEP: begin
                if (clr) begin
                    start_clr = 1'b1;
                end else if (ptr == '1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep pointer: restarts on every clr, advances while sweeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (start_clr) begin
            ptr <= '0;
        end else if (state == SWEEP) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Saturating event counters, zeroed when a sweep starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            mis_cnt   <= '0;
        end else if (start_clr) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            mis_cnt   <= '0;
        end else if (accept) begin
            if (br_cnt != '1) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if ((pred != taken) && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + CNT_W'(1);
            end
        end
    end

    // Predictor table: sweep rewrites one entry per cycle, otherwise
    // accepted branches train their entry with a saturating 2-bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl[IDX_W'(i)] <= 2'b01;
            end
        end else if (state == SWEEP) begin
            tbl[ptr] <= 2'b01;
        end else if (accept) begin
            if (taken) begin
                if (tbl[idx] != 2'b11) begin
                    tbl[idx] <= tbl[idx] + 2'b01;
                end
            end else begin
                if (tbl[idx] != 2'b00) begin
                    tbl[idx] <= tbl[idx] - 2'b01;
                end
            end
        end
    end

    // Registered misprediction pulse, one cycle after the accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict <= 1'b0;
        end else begin
            mispredict <= accept & (pred != taken);
        end
    end

    // Read mux over pre-update state
    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            2'd0: rd_mux = 32'(br_cnt);
            2'd1: rd_mux = 32'(taken_cnt);
            2'd2: rd_mux = 32'(mis_cnt);
`ifdef BRMON_GSHARE_EN
            2'd3: rd_mux = 32'({ghr, tbl[rd_idx]});
`else
            2'd3: rd_mux = 32'(tbl[rd_idx]);
`endif
            default: rd_mux = '0;
        endcase
    end

    // Read response register: data held until the next request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_branch_monitor.sv
// Scoreboard bench for branch_monitor (default bimodal build).
module tb_branch_monitor;

    localparam int CNT_W   = 4;
    localparam int IDX_W   = 6;
    localparam int ENTRIES = 64;
    localparam int CMAX    = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             inst_valid, seen, taken, int_taken, clr, rd_req;
    logic [31:0]      pc;
    logic [1:0]       rd_sel;
    logic [IDX_W-1:0] rd_idx;
    logic             busy, mispredict, rd_valid;
    logic [31:0]      rd_data;

    branch_monitor #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .seen(seen),
        .taken(taken), .int_taken(int_taken), .pc(pc), .clr(clr),
        .busy(busy), .mispredict(mispredict), .rd_req(rd_req),
        .rd_sel(rd_sel), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit mp;
        bit bsy;
        bit rv;
    } cyc_t;

    cyc_t cyc_q[$];
    int   rd_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state
    int m_br, m_tk, m_ms;
    int m_tbl[ENTRIES];
    bit m_sweep;
    int m_pos;

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
        end
    endfunction

    function automatic void model_reset();
        m_br = 0; m_tk = 0; m_ms = 0;
        m_sweep = 0; m_pos = 0;
        for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
    endfunction

    // One clock of stimulus; model predicts the effect of the following edge
    task automatic step(input bit iv, input bit sn, input bit tk, input bit it,
                        input logic [31:0] p, input bit cl, input bit rq,
                        input logic [1:0] sel, input logic [IDX_W-1:0] ix);
        cyc_t c;
        int   i;
        bit   pr;
        @(negedge clk);
        inst_valid = iv; seen = sn; taken = tk; int_taken = it; pc = p;
        clr = cl; rd_req = rq; rd_sel = sel; rd_idx = ix;
        if (rq) begin
            case (sel)
                2'd0: rd_q.push_back(m_br);
                2'd1: rd_q.push_back(m_tk);
                2'd2: rd_q.push_back(m_ms);
                default: rd_q.push_back(m_tbl[int'(ix)]);
            endcase
        end
        c.mp = 1'b0;
        c.rv = rq;
        if (m_sweep) m_tbl[m_pos] = 1;
        if (cl) begin
            m_br = 0; m_tk = 0; m_ms = 0;
            m_sweep = 1; m_pos = 0;
        end else if (m_sweep) begin
            if (m_pos == ENTRIES - 1) m_sweep = 0;
            else m_pos++;
        end else if (iv && sn && !it) begin
            i  = int'((p >> 2) & 32'(ENTRIES - 1));
            pr = (m_tbl[i] >= 2);
            if (m_br < CMAX) m_br++;
            if (tk && m_tk < CMAX) m_tk++;
            if (pr != tk) begin
                c.mp = 1'b1;
                if (m_ms < CMAX) m_ms++;
            end
            if (tk) m_tbl[i] = (m_tbl[i] == 3) ? 3 : m_tbl[i] + 1;
            else    m_tbl[i] = (m_tbl[i] == 0) ? 0 : m_tbl[i] - 1;
        end
        c.bsy = m_sweep;
        cyc_q.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 32'h0, 0, 0, 2'd0, '0);
    endtask

    task automatic rd(input logic [1:0] sel, input logic [IDX_W-1:0] ix);
        step(0, 0, 0, 0, 32'h0, 0, 1, sel, ix);
    endtask

    task automatic br(input bit tk, input logic [31:0] p);
        step(1, 1, tk, 0, p, 0, 0, 2'd0, '0);
    endtask

    task automatic read_counters();
        rd(2'd0, '0); rd(2'd1, '0); rd(2'd2, '0); rd(2'd3, '0);
    endtask

    // Monitor: compares every cycle the driver has predicted
    initial begin
        cyc_t c;
        int   e;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                chk("mispredict", int'(mispredict), int'(c.mp));
                chk("busy", int'(busy), int'(c.bsy));
                chk("rd_valid", int'(rd_valid), int'(c.rv));
                if (rd_valid) begin
                    if (rd_q.size() == 0) begin
                        chk("rd_unexpected", 1, 0);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rd_data", int'(rd_data), e);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected end before 300000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        inst_valid = 0; seen = 0; taken = 0; int_taken = 0; pc = '0;
        clr = 0; rd_req = 0; rd_sel = '0; rd_idx = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_mispredict", int'(mispredict), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        rst_n = 1'b1;

        // Reset contents
        read_counters();

        // Four taken branches on one entry
        repeat (4) br(1, 32'h100);
        read_counters();

        // Interrupt squashes the commit
        step(1, 1, 0, 1, 32'h100, 0, 0, 2'd0, '0);
        read_counters();

        // Drive the branch counter into saturation
        for (int k = 0; k < 13; k++) br(k[0], 32'h104 + 32'(k * 4));
        rd(2'd0, '0); rd(2'd1, '0); rd(2'd2, '0);
        br(0, 32'h180);
        rd(2'd0, '0);

        // Clear sweep with a commit and reads in the middle
        step(0, 0, 0, 0, 32'h0, 1, 0, 2'd0, '0);
        idle(20);
        br(1, 32'h200);
        rd(2'd0, '0);
        rd(2'd3, 6'd40);
        idle(50);
        read_counters();
        rd(2'd3, 6'd1); rd(2'd3, 6'd63);

        // clr and branch in the same cycle, then restart mid-sweep
        step(1, 1, 1, 0, 32'h100, 1, 0, 2'd0, '0);
        idle(30);
        step(0, 0, 0, 0, 32'h0, 1, 0, 2'd0, '0);
        idle(70);
        read_counters();

        // Reset asserted mid-sweep
        br(1, 32'h100); br(1, 32'h100); br(1, 32'h100);
        step(0, 0, 0, 0, 32'h0, 1, 0, 2'd0, '0);
        idle(10);
        @(negedge clk);
        rst_n = 1'b0;
        clr = 0; rd_req = 0; inst_valid = 0;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        read_counters();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom(), $urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                 IDX_W'($urandom_range(0, ENTRIES - 1)));
        end
        read_counters();
        idle(3);
        repeat (2) @(negedge clk);
        chk("cycle_queue_drained", cyc_q.size(), 0);
        chk("read_queue_drained", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
